// File: rtl/patch_ctrl_sequencer.sv
// Trigger-driven override sequencer: a scan-loaded match/mask watches obs_in and,
// on a hit, drives ctrl_val onto the ctrl_en-selected bits of sig_out for duration cycles.
module patch_ctrl_sequencer #(
  parameter int OBS_W  = 8,
  parameter int CTRL_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [OBS_W-1:0]  obs_in,
  input  logic [CTRL_W-1:0] sig_in,
  output logic [CTRL_W-1:0] sig_out,
  input  logic              cfg_en,
  input  logic              cfg_sdi,
  output logic              cfg_sdo,
  input  logic              cfg_load,
  output logic [1:0]        state_o,
  output logic              fired,
  output logic [CNT_W-1:0]  hit_cnt
);

  localparam int L = 2*OBS_W + 2*CTRL_W + CNT_W + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_ACTIVE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  logic [L-1:0]      r_shadow;
  logic [OBS_W-1:0]  r_match;
  logic [OBS_W-1:0]  r_mask;
  logic [CTRL_W-1:0] r_ctrl_val;
  logic [CTRL_W-1:0] r_ctrl_en;
  logic [CNT_W-1:0]  r_duration;
  logic              r_rearm;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [CTRL_W-1:0] r_ovr_sel;
  logic [CTRL_W-1:0] w_ovr_sel_nxt;
  logic [CTRL_W-1:0] r_ovr_val;
  logic [CTRL_W-1:0] w_ovr_val_nxt;
  logic              r_fired;
  logic              w_fired_nxt;
  logic [CNT_W-1:0]  r_hit_cnt;
  logic [CNT_W-1:0]  w_hit_cnt_nxt;

  logic              w_trig;
  logic              w_cfg_valid;

  // Load copies the pre-shift shadow when shift and load coincide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow   <= '0;
      r_match    <= '0;
      r_mask     <= '0;
      r_ctrl_val <= '0;
      r_ctrl_en  <= '0;
      r_duration <= '0;
      r_rearm    <= 1'b0;
    end else begin
      if (cfg_en) begin
        r_shadow <= {r_shadow[L-2:0], cfg_sdi};
      end
      if (cfg_load) begin
        {r_match, r_mask, r_ctrl_val, r_ctrl_en, r_duration, r_rearm} <= r_shadow;
      end
    end
  end

  assign cfg_sdo     = r_shadow[L-1];
  assign w_trig      = (((obs_in ^ r_match) & r_mask) == '0) && (r_mask != '0);
  assign w_cfg_valid = (r_mask != '0) && (r_ctrl_en != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_ovr_sel <= '0;
      r_ovr_val <= '0;
      r_fired   <= 1'b0;
      r_hit_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_ovr_sel <= w_ovr_sel_nxt;
      r_ovr_val <= w_ovr_val_nxt;
      r_fired   <= w_fired_nxt;
      r_hit_cnt <= w_hit_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_ovr_sel_nxt = r_ovr_sel;
    w_ovr_val_nxt = r_ovr_val;
    w_fired_nxt   = r_fired;
    w_hit_cnt_nxt = r_hit_cnt;
    if (cfg_load) begin
      w_state_nxt   = S_IDLE;
      w_cnt_nxt     = '0;
      w_ovr_sel_nxt = '0;
      w_fired_nxt   = 1'b0;
      w_hit_cnt_nxt = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_cfg_valid) begin
            w_state_nxt = S_ARMED;
          end
        end
        S_ARMED: begin
          if (w_trig) begin
            w_state_nxt   = S_ACTIVE;
            w_cnt_nxt     = r_duration - CNT_W'(1);
            w_ovr_sel_nxt = r_ctrl_en;
            w_ovr_val_nxt = r_ctrl_val;
          end
        end
        S_ACTIVE: begin
          // A zero duration holds the override until the next load or reset.
          if (r_duration != '0) begin
            if (r_cnt == '0) begin
              w_state_nxt   = S_DONE;
              w_ovr_sel_nxt = '0;
              w_fired_nxt   = 1'b1;
              if (r_hit_cnt != '1) begin
                w_hit_cnt_nxt = r_hit_cnt + CNT_W'(1);
              end
            end else begin
              w_cnt_nxt = r_cnt - CNT_W'(1);
            end
          end
        end
        S_DONE: begin
          if (r_rearm) begin
            w_state_nxt = S_ARMED;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  assign sig_out = (r_ovr_sel & r_ovr_val) | (~r_ovr_sel & sig_in);
  assign state_o = r_state;
  assign fired   = r_fired;
  assign hit_cnt = r_hit_cnt;

endmodule

// File: tb/tb_patch_ctrl_sequencer.sv
// Directed bench for patch_ctrl_sequencer: event-level reference model checked every
// falling edge, plus hand-computed expectations for override length, counts and scan delay.
module tb_patch_ctrl_sequencer;

  localparam int L = 33;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] obs_in = '0;
  logic [3:0] sig_in = '0;
  logic [3:0] sig_out;
  logic       cfg_en = 1'b0;
  logic       cfg_sdi = 1'b0;
  logic       cfg_sdo;
  logic       cfg_load = 1'b0;
  logic [1:0] state_o;
  logic       fired;
  logic [7:0] hit_cnt;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  patch_ctrl_sequencer #(.OBS_W(8), .CTRL_W(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .obs_in(obs_in), .sig_in(sig_in), .sig_out(sig_out),
    .cfg_en(cfg_en), .cfg_sdi(cfg_sdi), .cfg_sdo(cfg_sdo), .cfg_load(cfg_load),
    .state_o(state_o), .fired(fired), .hit_cnt(hit_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: config as a packed vector, the override tracked as cycles remaining.
  logic [L-1:0] m_shadow = '0;
  logic [L-1:0] m_cfg = '0;
  int           m_st = 0;
  int           m_left = 0;
  logic [3:0]   m_sel = '0;
  logic [3:0]   m_val = '0;
  logic         m_fired = 1'b0;
  int           m_hits = 0;

  always @(posedge clk or posedge rst) begin : model
    logic [L-1:0] pre;
    logic [7:0]   mt, mk;
    logic [3:0]   cv, ce;
    logic [7:0]   dur;
    logic         rearm;
    if (rst) begin
      m_shadow = '0; m_cfg = '0; m_st = 0; m_left = 0;
      m_sel = '0; m_val = '0; m_fired = 1'b0; m_hits = 0;
    end else begin
      {mt, mk, cv, ce, dur, rearm} = m_cfg;
      pre = m_shadow;
      if (cfg_en) m_shadow = {m_shadow[L-2:0], cfg_sdi};
      if (cfg_load) begin
        m_cfg = pre; m_st = 0; m_left = 0; m_sel = '0; m_fired = 1'b0; m_hits = 0;
      end else if (m_st == 0) begin
        if (mk != 0 && ce != 0) m_st = 1;
      end else if (m_st == 1) begin
        if ((((obs_in ^ mt) & mk) == 0) && mk != 0) begin
          m_st = 2; m_sel = ce; m_val = cv;
          m_left = (dur == 0) ? -1 : int'(dur);
        end
      end else if (m_st == 2) begin
        if (m_left > 0) begin
          m_left--;
          if (m_left == 0) begin
            m_st = 3; m_sel = '0; m_fired = 1'b1;
            if (m_hits < 255) m_hits++;
          end
        end
      end else begin
        if (rearm) m_st = 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("state_o", state_o, m_st);
    chk("sig_out", sig_out, (m_sel & m_val) | (~m_sel & sig_in));
    chk("fired", fired, m_fired);
    chk("hit_cnt", hit_cnt, m_hits);
    chk("cfg_sdo", cfg_sdo, m_shadow[L-1]);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scan(input logic [L-1:0] v);
    for (int i = L-1; i >= 0; i--) begin
      cfg_en = 1'b1; cfg_sdi = v[i];
      tick();
    end
    cfg_en = 1'b0; cfg_sdi = 1'b0;
  endtask

  task automatic load();
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
  endtask

  function automatic logic [L-1:0] pack(input logic [7:0] mt, input logic [7:0] mk,
                                        input logic [3:0] cv, input logic [3:0] ce,
                                        input logic [7:0] dur, input logic rearm);
    return {mt, mk, cv, ce, dur, rearm};
  endfunction

  task automatic count_ovr(input int n, input logic [3:0] ov, output int c);
    c = 0;
    for (int i = 0; i < n; i++) begin
      if (sig_out === ov) c++;
      tick();
    end
  endtask

  initial begin
    logic [3:0]   pats [4];
    logic [7:0]   obs_pats [4];
    logic [L-1:0] pat;
    logic [L-1:0] got;
    int c, total;

    pats = '{4'h0, 4'h5, 4'hA, 4'hF};
    obs_pats = '{8'h00, 8'hFF, 8'hA5, 8'h5A};

    // Reset state with no load
    #1 rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sig_in = pats[i];
      #2;
      chk("rst_passthru", sig_out, pats[i]);
    end
    chk("rst_state", state_o, 0);
    chk("rst_sdo", cfg_sdo, 0);
    chk("rst_hits", hit_cnt, 0);
    tick(); tick();
    rst = 1'b0;
    tick(); tick();
    chk("noload_state", state_o, 0);

    // One-shot override, duration 4
    sig_in = 4'hC;
    scan(pack(8'hA5, 8'hFF, 4'h3, 4'hF, 8'd4, 1'b0));
    load();
    chk("t2_idle", state_o, 0);
    tick();
    chk("t2_armed", state_o, 1);
    obs_in = 8'hA5;
    tick();
    obs_in = 8'h00;
    chk("t2_first", sig_out, 4'h3);
    count_ovr(10, 4'h3, c);
    chk("t2_len", c, 4);
    chk("t2_done", state_o, 3);
    chk("t2_fired", fired, 1);
    chk("t2_hits", hit_cnt, 1);
    obs_in = 8'hA5;
    count_ovr(6, 4'h3, c);
    obs_in = 8'h00;
    chk("t2_noretrig", c, 0);
    chk("t2_hits_hold", hit_cnt, 1);

    // Rearm with partial mask
    scan(pack(8'hA5, 8'hF0, 4'h3, 4'hF, 8'd4, 1'b1));
    load();
    tick();
    total = 0;
    for (int k = 0; k < 3; k++) begin
      obs_in = 8'hA0 + 8'(k * 7);
      tick();
      obs_in = 8'h00;
      count_ovr(7, 4'h3, c);
      total += c;
    end
    chk("t3_total", total, 12);
    chk("t3_hits", hit_cnt, 3);
    obs_in = 8'h5A;
    count_ovr(8, 4'h3, c);
    obs_in = 8'h00;
    chk("t3_5a", c, 0);
    chk("t3_armed", state_o, 1);

    // Sticky override, duration 0
    sig_in = 4'hF;
    scan(pack(8'h12, 8'hFF, 4'h0, 4'h2, 8'd0, 1'b0));
    load();
    tick();
    obs_in = 8'h12;
    tick();
    obs_in = 8'h00;
    count_ovr(20, 4'hD, c);
    chk("t4_sticky", c, 20);
    chk("t4_active", state_o, 2);
    load();
    chk("t4_release", sig_out, 4'hF);
    chk("t4_idle", state_o, 0);
    chk("t4_fired", fired, 0);

    // Invalid configurations never arm
    sig_in = 4'hC;
    scan(pack(8'h00, 8'h00, 4'h3, 4'hF, 8'd2, 1'b1));
    load();
    total = 0;
    for (int i = 0; i < 4; i++) begin
      obs_in = obs_pats[i];
      count_ovr(2, 4'h3, c);
      total += c;
    end
    chk("t5_mask0_ovr", total, 0);
    chk("t5_mask0_state", state_o, 0);
    scan(pack(8'hA5, 8'hFF, 4'h3, 4'h0, 8'd2, 1'b1));
    load();
    obs_in = 8'hA5;
    count_ovr(4, 4'h3, c);
    obs_in = 8'h00;
    chk("t5_en0_ovr", c, 0);
    chk("t5_en0_state", state_o, 0);

    // Scan-out delay
    pat = 33'h1_B3C5_A96D;
    got = '0;
    for (int j = 0; j < 2*L; j++) begin
      cfg_en = 1'b1;
      cfg_sdi = (j < L) ? pat[j] : 1'b0;
      tick();
      if (j >= L-1 && j < 2*L-1) got[j-(L-1)] = cfg_sdo;
    end
    cfg_en = 1'b0; cfg_sdi = 1'b0;
    chk("t5_sdo_delay", got, pat);

    // Asynchronous reset mid-override
    scan(pack(8'hA5, 8'hFF, 4'h3, 4'hF, 8'd4, 1'b0));
    load();
    tick();
    obs_in = 8'hA5;
    tick();
    obs_in = 8'h00;
    tick();
    chk("t6_pre_rst", sig_out, 4'h3);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_out", sig_out, 4'hC);
    chk("t6_async_state", state_o, 0);
    chk("t6_async_sdo", cfg_sdo, 0);
    tick();
    rst = 1'b0;
    tick(); tick(); tick();
    chk("t6_cfg_cleared", state_o, 0);
    obs_in = 8'hA5;
    count_ovr(4, 4'h3, c);
    obs_in = 8'h00;
    chk("t6_no_ovr", c, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/patch_ctrl_sequencer.md
Name: patch_ctrl_sequencer

Overview:
- Trigger-driven override controller for patch-instrumented signals.
- Watches a bus of observe-tapped signals and compares it against a scan-loaded match/mask.
- On a hit, drives override values onto the control-tapped signals for a programmed number of cycles.
- Sits between the observe taps, the control-tap muxes and the patch configuration scan chain.

Parameters:
OBS_W, 8, width of observed signal bus
CTRL_W, 4, width of controllable signal bus
CNT_W, 8, width of override duration counter

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
obs_in  input  OBS_W  observed signals (synchronous to clk)
sig_in  input  CTRL_W  functional values of controllable signals
sig_out  output  CTRL_W  patched values driven to the design
cfg_en  input  1  scan shift enable
cfg_sdi  input  1  scan serial data in
cfg_sdo  output  1  scan serial data out (chainable)
cfg_load  input  1  copy shadow chain to active config (pulse)
state_o  output  2  FSM state: 0 IDLE, 1 ARMED, 2 ACTIVE, 3 DONE
fired  output  1  sticky: override has occurred since last load
hit_cnt  output  CNT_W  number of completed overrides, saturating

Behaviour:
Interface:
- One clock, clk.
- Reset rst is asynchronous and active-high.

Scan chain and config:
- Shadow chain length L = 2*OBS_W + 2*CTRL_W + CNT_W + 1 (33 at defaults).
- Field order MSB->LSB: match[OBS_W], mask[OBS_W], ctrl_val[CTRL_W], ctrl_en[CTRL_W], duration[CNT_W], rearm[1].
- Shift: when cfg_en=1, shadow <= {shadow[L-2:0], cfg_sdi}; the first bit shifted in ends at the MSB.
- cfg_sdo = shadow[L-1], registered.
- Shift does not disturb the active config.
- cfg_load=1: active config <= shadow.
  - FSM forced to IDLE; override dropped the same edge; fired and hit_cnt cleared.
  - If cfg_en and cfg_load are both 1, shift and load happen together and the load takes the pre-shift shadow.

Trigger:
- trig = (((obs_in ^ match) & mask) == 0) && (mask != 0).
- mask=0 never triggers.

FSM, registered:
- IDLE: go to ARMED next edge if config is valid (mask != 0 and ctrl_en != 0); else stay in IDLE.
- ARMED: on trig, go to ACTIVE and load cnt <= duration-1.
- ACTIVE: ovr_sel = ctrl_en and ovr_val = ctrl_val, both registered and set on the entry edge.
  - If duration=0: sticky, stay in ACTIVE until cfg_load or reset.
  - Else if cnt==0: go to DONE, clear ovr_sel, set fired, hit_cnt++ (saturating at all-ones).
  - Else cnt--.
- DONE: if rearm=1, go to ARMED next edge; else hold in DONE.
- trig ignored in IDLE, ACTIVE and DONE.

Output mux (combinational from registered select):
- sig_out[i] = ovr_sel[i] ? ovr_val[i] : sig_in[i].

Latency:
- trig true at edge k -> sig_out overridden from just after edge k through edge k+D, restored after edge k+D.
- Override length is exactly D cycles for duration=D>0.

Reset:
- All config, shadow, cnt, ovr_sel and ovr_val = 0; state IDLE; fired=0; hit_cnt=0; cfg_sdo=0; sig_out = sig_in.
- Reset mid-override drops the override immediately (asynchronously).

Test Plan:
- Reset then no load -> state_o=0, sig_out==sig_in for arbitrary sig_in, cfg_sdo=0, hit_cnt=0.
- Scan match=0xA5, mask=0xFF, ctrl_val=0x3, ctrl_en=0xF, duration=4, rearm=0, then pulse cfg_load; drive obs_in=0xA5 at edge k -> sig_out=0x3 for exactly 4 cycles, then sig_out=sig_in; state DONE; fired=1; hit_cnt=1; a second 0xA5 gives no override.
- Same config with rearm=1 and mask=0xF0, obs_in=0xAx pulsed 3 times with gaps ≥6 cycles -> 3 separate 4-cycle overrides, hit_cnt=3; obs_in=0x5A gives no trigger.
- duration=0, ctrl_en=0x2, ctrl_val=0x0, sig_in=0xF -> after trigger sig_out=0xD held indefinitely; cfg_load -> sig_out=0xF next cycle, state IDLE, fired=0.
- mask=0 or ctrl_en=0 loaded -> state stays IDLE, no override for any obs_in; shift 33 known bits plus 33 zeros -> cfg_sdo reproduces the input pattern delayed by 33 cycles.
- Assert rst mid-ACTIVE (cycle 2 of 4) -> sig_out=sig_in without waiting for a clock edge, state IDLE, config cleared.
